inertial_interface: RTL and testbench
=====================================

INERTIAL_INTERFACE -- requirements
Module: inertial_interface

Interface
REQ-001 Parameter INIT_WAIT, default 65535, power-up delay in clk cycles before IMU configuration begins (range 1..65535).
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 INT  input  1  IMU data-ready interrupt, asynchronous, active-high level.
REQ-005 done  input  1  SPI master transaction-complete pulse, one cycle.
REQ-006 rd_data  input  16  SPI master read data; valid only in the cycle done=1.
REQ-007 wrt  output  1  one-cycle pulse starting an SPI transaction.
REQ-008 cmd  output  16  SPI command word; stable from the wrt cycle until done.
REQ-009 ptch_rt  output  16  signed pitch rate {high byte, low byte}, registered.
REQ-010 AZ  output  16  signed Z acceleration {high byte, low byte}, registered.
REQ-011 vld  output  1  one-cycle pulse: ptch_rt and AZ hold a new sample.

Function
REQ-012 The block SHALL run a 16-bit timer from 0 after reset; configuration SHALL start on the cycle after the timer reaches INIT_WAIT.
REQ-013 Configuration SHALL issue four writes, in order: 0x0D02, 0x1053, 0x1150, 0x1460.
REQ-014 Each transaction SHALL be: assert wrt for exactly one cycle with cmd valid, then wait for done, then issue the next wrt no earlier than the cycle after done.
REQ-015 After the fourth configuration done, the block SHALL enter WAIT_INT and never re-enter the configuration states except through reset.
REQ-016 INT SHALL pass through a two-flop synchronizer; a read sequence SHALL start when synchronized INT=1 is sampled in WAIT_INT.
REQ-017 A read sequence SHALL issue four reads, in order: 0xA200 (pitch low), 0xA300 (pitch high), 0xAC00 (AZ low), 0xAD00 (AZ high).
REQ-018 On each read done, rd_data[7:0] SHALL be captured into the corresponding byte holding register; rd_data[15:8] SHALL be ignored.
REQ-019 On the clock edge sampling done for the AZ-high read, ptch_rt SHALL load {pitch_high, pitch_low}, AZ SHALL load {rd_data[7:0], AZ_low}, vld SHALL go 1 for exactly one cycle, and the state SHALL return to WAIT_INT.
REQ-020 ptch_rt and AZ SHALL change only at the edge in REQ-019; partial reads SHALL never be visible on the outputs.
REQ-021 The state machine SHALL contain states WAIT_PWR, CFG1, CFG2, CFG3, CFG4, WAIT_INT, RD_PL, RD_PH, RD_AL, and RD_AH.
REQ-022 done received while no transaction is outstanding SHALL be ignored.
REQ-023 INT asserted during configuration or during a read sequence SHALL be ignored; if INT is still high on return to WAIT_INT, a new sequence SHALL start on the next cycle.
REQ-024 The block SHALL wait indefinitely for done; it SHALL have no timeout and SHALL NOT issue a second wrt.
REQ-025 Back-to-back samples: the minimum spacing between consecutive vld pulses SHALL be bounded only by SPI done latency.

Reset
REQ-026 On rst_n=0, the block SHALL immediately force state to WAIT_PWR, timer to 0, wrt=0, cmd=0x0000, ptch_rt=0x0000, AZ=0x0000, vld=0, all holding registers to 0, and both synchronizer flops to 0.
REQ-027 Reset asserted mid-transaction SHALL abandon that transaction; after release, the full power-up wait and configuration SHALL be repeated.

Verification
REQ-028 Power-up, INIT_WAIT=16, done returned 5 cycles after each wrt -> exactly four wrt pulses with cmd 0x0D02, 0x1053, 0x1150, 0x1460 in order; the first wrt occurs no earlier than 17 cycles after reset release.
REQ-029 Assert INT after configuration; rd_data low bytes 0x34, 0x12, 0xCD, 0xAB -> cmds 0xA200, 0xA300, 0xAC00, 0xAD00 issued; ptch_rt=0x1234, AZ=0xABCD with a single-cycle vld on the same edge.
REQ-030 rd_data high bytes 0xFF on every read, low bytes 0x00, 0x80, 0x01, 0xFF -> ptch_rt=0x8000, AZ=0xFF01; the upper bytes are ignored.
REQ-031 INT pulsed during RD_PH, then low at return -> no second sequence starts; INT held high -> second sequence starts the cycle after WAIT_INT is re-entered.
REQ-032 Spurious done in WAIT_INT -> no state change, no vld; rst_n pulsed low during RD_AL -> outputs read 0x0000 immediately and configuration repeats after INIT_WAIT.

Source files
------------

// File: rtl/inertial_interface.sv
// IMU front end: waits out power-up, programs four config registers over SPI,
// then reads pitch rate and Z acceleration byte-wise on each data-ready interrupt.
module inertial_interface #(
  parameter int INIT_WAIT = 65535
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               INT,
  input  logic               done,
  input  logic [15:0]        rd_data,
  output logic               wrt,
  output logic [15:0]        cmd,
  output logic signed [15:0] ptch_rt,
  output logic signed [15:0] AZ,
  output logic               vld
);

  localparam logic [15:0] LP_WAIT = 16'(INIT_WAIT);

  typedef enum logic [3:0] {
    WAIT_PWR, CFG1, CFG2, CFG3, CFG4, WAIT_INT, RD_PL, RD_PH, RD_AL, RD_AH
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [15:0]        r_timer;
  logic               r_int_ff1;
  logic               r_int_ff2;
  logic               r_pend;
  logic [7:0]         r_pl;
  logic [7:0]         r_ph;
  logic [7:0]         r_al;
  logic               r_wrt;
  logic [15:0]        r_cmd;
  logic signed [15:0] r_ptch;
  logic signed [15:0] r_az;
  logic               r_vld;
  logic               w_issue;
  logic               w_ack;
  logic               w_xfer;
  logic [15:0]        w_cmd;

  // Every transfer state issues exactly one wrt, then parks until its done.
  always_comb begin
    w_next = r_state;
    w_cmd  = 16'h0000;
    w_xfer = 1'b1;
    w_ack  = r_pend & done;
    case (r_state)
      WAIT_PWR: begin
        w_xfer = 1'b0;
        if (r_timer == LP_WAIT) w_next = CFG1;
      end
      CFG1: begin w_cmd = 16'h0D02; if (w_ack) w_next = CFG2;     end
      CFG2: begin w_cmd = 16'h1053; if (w_ack) w_next = CFG3;     end
      CFG3: begin w_cmd = 16'h1150; if (w_ack) w_next = CFG4;     end
      CFG4: begin w_cmd = 16'h1460; if (w_ack) w_next = WAIT_INT; end
      WAIT_INT: begin
        w_xfer = 1'b0;
        if (r_int_ff2) w_next = RD_PL;
      end
      RD_PL: begin w_cmd = 16'hA200; if (w_ack) w_next = RD_PH;    end
      RD_PH: begin w_cmd = 16'hA300; if (w_ack) w_next = RD_AL;    end
      RD_AL: begin w_cmd = 16'hAC00; if (w_ack) w_next = RD_AH;    end
      RD_AH: begin w_cmd = 16'hAD00; if (w_ack) w_next = WAIT_INT; end
      default: begin
        w_xfer = 1'b0;
        w_next = WAIT_PWR;
      end
    endcase
    w_issue = w_xfer & ~r_pend;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= WAIT_PWR;
      r_timer   <= 16'h0000;
      r_int_ff1 <= 1'b0;
      r_int_ff2 <= 1'b0;
      r_pend    <= 1'b0;
      r_pl      <= 8'h00;
      r_ph      <= 8'h00;
      r_al      <= 8'h00;
      r_wrt     <= 1'b0;
      r_cmd     <= 16'h0000;
      r_ptch    <= 16'sh0000;
      r_az      <= 16'sh0000;
      r_vld     <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_int_ff1 <= INT;
      r_int_ff2 <= r_int_ff1;
      if (r_state == WAIT_PWR && r_timer != LP_WAIT) r_timer <= r_timer + 16'd1;
      r_wrt <= w_issue;
      r_vld <= 1'b0;
      if (w_issue) begin
        r_cmd  <= w_cmd;
        r_pend <= 1'b1;
      end else if (w_ack) begin
        r_pend <= 1'b0;
      end
      // Outputs move only on the final byte so a partial sample is never visible.
      if (w_ack) begin
        case (r_state)
          RD_PL: r_pl <= rd_data[7:0];
          RD_PH: r_ph <= rd_data[7:0];
          RD_AL: r_al <= rd_data[7:0];
          RD_AH: begin
            r_ptch <= {r_ph, r_pl};
            r_az   <= {rd_data[7:0], r_al};
            r_vld  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign wrt     = r_wrt;
  assign cmd     = r_cmd;
  assign ptch_rt = r_ptch;
  assign AZ      = r_az;
  assign vld     = r_vld;

endmodule

// File: tb/tb_inertial_interface.sv
// Scoreboard bench for inertial_interface: SPI slave model answers each wrt
// five cycles later; expected commands and samples are queued as stimulus is set up.
module tb_inertial_interface;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               INT;
  logic               done;
  logic [15:0]        rd_data;
  logic               wrt;
  logic [15:0]        cmd;
  logic signed [15:0] ptch_rt;
  logic signed [15:0] AZ;
  logic               vld;

  inertial_interface #(.INIT_WAIT(16)) dut (
    .clk(clk), .rst_n(rst_n), .INT(INT), .done(done), .rd_data(rd_data),
    .wrt(wrt), .cmd(cmd), .ptch_rt(ptch_rt), .AZ(AZ), .vld(vld)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] exp_cmd[$];
  logic [15:0] rd_q[$];
  logic [31:0] exp_out[$];
  int n_checks = 0;
  int n_errors = 0;
  int wrt_cnt = 0;
  int vld_cnt = 0;
  int rel_cyc = 0;
  int vld_cyc = 0;
  int a200_cyc = 0;
  bit need_lat = 0;
  bit busy = 0;
  bit spur_req = 0;
  bit prev_vld = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_cfg();
    exp_cmd.push_back(16'h0D02);
    exp_cmd.push_back(16'h1053);
    exp_cmd.push_back(16'h1150);
    exp_cmd.push_back(16'h1460);
  endtask

  task automatic start_read(input logic [7:0] pl, input logic [7:0] ph,
                            input logic [7:0] al, input logic [7:0] ah,
                            input logic [7:0] hi);
    exp_cmd.push_back(16'hA200);
    exp_cmd.push_back(16'hA300);
    exp_cmd.push_back(16'hAC00);
    exp_cmd.push_back(16'hAD00);
    rd_q.push_back({hi, pl});
    rd_q.push_back({hi, ph});
    rd_q.push_back({hi, al});
    rd_q.push_back({hi, ah});
    exp_out.push_back({ph, pl, ah, al});
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((exp_cmd.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'b0, (exp_cmd.size() == 0 && !busy)}, 32'd1);
  endtask

  task automatic wait_vld(input string tag, input int target, input int budget);
    int n = 0;
    while (vld_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, vld_cnt, target);
  endtask

  task automatic wait_left(input string tag, input int left, input int budget);
    int n = 0;
    while (exp_cmd.size() > left && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, exp_cmd.size(), left);
  endtask

  // Output monitor: every wrt and vld is matched against the scoreboard.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (wrt) begin
        wrt_cnt++;
        if (need_lat) begin
          chk("first_wrt_latency_ge17", {31'b0, (cyc - rel_cyc) >= 17}, 32'd1);
          need_lat = 0;
        end
        if (cmd == 16'hA200) a200_cyc = cyc;
        if (exp_cmd.size() == 0) chk("wrt_unexpected_cmd", {16'h0, cmd}, 32'd0);
        else chk("cmd", {16'h0, cmd}, {16'h0, exp_cmd.pop_front()});
      end
      if (vld) begin
        vld_cnt++;
        vld_cyc = cyc;
        chk("vld_width", {31'b0, prev_vld}, 32'd0);
        if (exp_out.size() == 0) chk("vld_unexpected", {ptch_rt, AZ}, 32'hDEADBEEF);
        else chk("sample", {ptch_rt, AZ}, exp_out.pop_front());
      end
      prev_vld = vld;
    end
  endtask

  // SPI slave: done five cycles after each wrt; rd_data from the read queue.
  task automatic responder();
    logic [15:0] c;
    forever begin
      @(negedge clk);
      if (spur_req) begin
        rd_data = 16'hFFFF;
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        rd_data = 16'h0000;
        spur_req = 0;
      end else if (wrt) begin
        busy = 1;
        c = cmd;
        repeat (4) @(negedge clk);
        if (c[15:12] == 4'hA && rd_q.size() > 0) rd_data = rd_q.pop_front();
        else rd_data = 16'h0000;
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        rd_data = 16'h0000;
        busy = 0;
      end
    end
  endtask

  int w_base;
  int v_base;

  initial begin
    rst_n = 1'b0;
    INT = 1'b0;
    done = 1'b0;
    rd_data = 16'h0000;
    fork
      monitor();
      responder();
      begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(negedge clk);
    chk("reset_outputs", {ptch_rt, AZ}, 32'h0);
    chk("reset_cmd", {15'b0, wrt, cmd}, 32'h0);
    chk("reset_vld", {31'b0, vld}, 32'h0);

    // Power-up and configuration
    push_cfg();
    rst_n = 1'b1;
    rel_cyc = cyc;
    need_lat = 1;
    wait_idle("cfg_complete", 300);
    repeat (10) @(negedge clk);
    chk("cfg_wrt_count", wrt_cnt, 4);

    // Basic read
    start_read(8'h34, 8'h12, 8'hCD, 8'hAB, 8'h00);
    INT = 1'b1;
    repeat (4) @(negedge clk);
    INT = 1'b0;
    wait_vld("read1_vld", 1, 200);

    // Upper bytes ignored, sign boundaries
    start_read(8'h00, 8'h80, 8'h01, 8'hFF, 8'hFF);
    INT = 1'b1;
    repeat (4) @(negedge clk);
    INT = 1'b0;
    wait_vld("read2_vld", 2, 200);

    // INT pulse during RD_PH, low at return: no second sequence
    w_base = wrt_cnt;
    start_read(8'h11, 8'h22, 8'h33, 8'h44, 8'h00);
    INT = 1'b1;
    repeat (4) @(negedge clk);
    INT = 1'b0;
    wait_left("reach_rd_ph", 2, 200);
    INT = 1'b1;
    repeat (2) @(negedge clk);
    INT = 1'b0;
    wait_vld("read3_vld", 3, 200);
    repeat (30) @(negedge clk);
    chk("int_pulse_ignored_wrts", wrt_cnt - w_base, 4);

    // INT held high: back-to-back sequences
    start_read(8'h55, 8'h66, 8'h77, 8'h08, 8'h00);
    start_read(8'hEE, 8'hDD, 8'hCC, 8'hBB, 8'h00);
    INT = 1'b1;
    wait_vld("read4a_vld", 4, 200);
    wait_left("read4b_start", 3, 50);
    INT = 1'b0;
    chk("int_held_restart_gap", a200_cyc - vld_cyc, 2);
    wait_vld("read4b_vld", 5, 200);
    repeat (10) @(negedge clk);

    // Spurious done in WAIT_INT
    w_base = wrt_cnt;
    v_base = vld_cnt;
    spur_req = 1;
    repeat (12) @(negedge clk);
    chk("spur_vld", vld_cnt, v_base);
    chk("spur_wrt", wrt_cnt, w_base);
    chk("spur_outputs", {ptch_rt, AZ}, 32'hDDEEBBCC);
    start_read(8'hFF, 8'h7F, 8'h00, 8'h80, 8'h00);
    INT = 1'b1;
    repeat (4) @(negedge clk);
    INT = 1'b0;
    wait_vld("read5_vld", 6, 200);

    // Reset during RD_AL
    start_read(8'h99, 8'h88, 8'h77, 8'h66, 8'h00);
    INT = 1'b1;
    repeat (4) @(negedge clk);
    INT = 1'b0;
    wait_left("reach_rd_al", 1, 200);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", {ptch_rt, AZ}, 32'h0);
    chk("midreset_cmd", {15'b0, wrt, cmd}, 32'h0);
    exp_cmd.delete();
    rd_q.delete();
    exp_out.delete();
    v_base = vld_cnt;
    repeat (3) @(negedge clk);
    push_cfg();
    w_base = wrt_cnt;
    rst_n = 1'b1;
    rel_cyc = cyc;
    need_lat = 1;
    wait_idle("recfg_complete", 300);
    repeat (10) @(negedge clk);
    chk("recfg_wrt_count", wrt_cnt - w_base, 4);
    chk("abandoned_no_vld", vld_cnt, v_base);

    start_read(8'h01, 8'h00, 8'h02, 8'h00, 8'h00);
    INT = 1'b1;
    repeat (4) @(negedge clk);
    INT = 1'b0;
    wait_vld("read6_vld", v_base + 1, 200);
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
